muldiv: RTL and testbench

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv_pkg.sv | 45 ++++
 rtl/muldiv.sv | 257 +++++++++++++++++++++++++
 tb/tb_muldiv.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared core definitions for the RV32M multiply/divide unit: funct3 operation
// encodings (also used by the instruction decoder), the unit's FSM state
// encoding, and small helpers that classify operations by operand signedness.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    // RV32M funct3 encodings (OP opcode, funct7 = 0000001)
    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } md_op_e;

    // Multiply/divide unit sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // Divide/remainder ops all have funct3[2] set
    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    // rs1 is interpreted as signed for MULH, MULHSU, DIV, REM
    function automatic logic op_rs1_signed(input md_op_e op);
        return (op == F3_MULH) || (op == F3_MULHSU) ||
               (op == F3_DIV)  || (op == F3_REM);
    endfunction

    // rs2 is interpreted as signed for MULH, DIV, REM
    function automatic logic op_rs2_signed(input md_op_e op);
        return (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv.sv
// -----------------------------------------------------------------------------
// muldiv
// Iterative RV32M multiply/divide unit with a fixed latency for every op.
// A request is accepted in IDLE, runs W single-bit iterations in CALC through
// one shared adder/subtractor (shift-add multiply or restoring divide), applies
// sign correction and special cases in FIX, and presents the result in DONE.
//
// Ports:
//   clk      in   clock, all state on rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only while ready=1
//   funct3   in   RV32M operation (md_op_e encoding)
//   rs1_val  in   operand A
//   rs2_val  in   operand B
//   rd_in    in   destination register of the request
//   kill     in   synchronous abort of the in-flight op
//   ready    out  high only in IDLE
//   done     out  one-cycle completion pulse
//   wr_en    out  register-file write enable (done with rd != 0)
//   rd       out  register-file write index
//   rd_val   out  register-file write data
// -----------------------------------------------------------------------------
module muldiv
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   funct3,
    input  logic [W-1:0] rs1_val,
    input  logic [W-1:0] rs2_val,
    input  logic [4:0]   rd_in,
    input  logic         kill,
    output logic         ready,
    output logic         done,
    output logic         wr_en,
    output logic [4:0]   rd,
    output logic [W-1:0] rd_val
);

    localparam logic [4:0] LAST_ITER = 5'(W - 1);

    // Sequencing state
    md_state_e    state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    md_op_e       op_q, op_d;
    logic [4:0]   rd_lat_q, rd_lat_d;

    // Datapath: {hi, lo} is the product (multiply) or {remainder, quotient}
    // (divide); b holds the multiplicand/divisor magnitude.
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] a_q, a_d;          // original rs1, for remainder-by-zero
    logic         neg_q, neg_d;      // negate product / quotient in FIX
    logic         neg_rem_q, neg_rem_d;
    logic         bzero_q, bzero_d;

    // Registered outputs
    logic         ready_q, ready_d;
    logic         done_q, done_d;
    logic         wr_en_q, wr_en_d;
    logic [4:0]   rd_q, rd_d;
    logic [W-1:0] rd_val_q, rd_val_d;

    // ---------------------------------------------------------------------
    // Operand conditioning at accept: signed operands become magnitudes.
    // ---------------------------------------------------------------------
    md_op_e       op_in;
    logic         s1_neg, s2_neg;
    logic [W-1:0] a_mag, b_mag;

    always_comb begin
        op_in  = md_op_e'(funct3);
        s1_neg = op_rs1_signed(op_in) && rs1_val[W-1];
        s2_neg = op_rs2_signed(op_in) && rs2_val[W-1];
        a_mag  = s1_neg ? (~rs1_val + 1'b1) : rs1_val;
        b_mag  = s2_neg ? (~rs2_val + 1'b1) : rs2_val;
    end

    // ---------------------------------------------------------------------
    // Shared adder/subtractor, W+2 bits wide.
    //   multiply: hi + (lo[0] ? b : 0)           carry lands in bit W
    //   divide:   {hi, lo[W-1]} - b              bit W+1 is the borrow/sign
    // The shifted partial remainder can be W+1 bits, so the extra bit keeps
    // the subtraction sign unambiguous.
    // ---------------------------------------------------------------------
    logic         is_div;
    logic [W+1:0] add_a, add_b, add_sum;

    always_comb begin
        is_div  = op_is_div(op_q);
        add_a   = is_div ? {1'b0, hi_q, lo_q[W-1]} : {2'b00, hi_q};
        add_b   = is_div ? ~{2'b00, b_q}
                         : (lo_q[0] ? {2'b00, b_q} : '0);
        add_sum = add_a + add_b + {{(W+1){1'b0}}, is_div};
    end

    // ---------------------------------------------------------------------
    // FIX-stage result selection with sign correction and divide special
    // cases. Signed overflow (most-negative / -1) falls out naturally: the
    // magnitude quotient 2^(W-1) negated is itself, and the remainder is 0.
    // ---------------------------------------------------------------------
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, result;

    always_comb begin
        prod_fix = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
        quo_fix  = bzero_q ? '1  : (neg_q     ? (~lo_q + 1'b1) : lo_q);
        rem_fix  = bzero_q ? a_q : (neg_rem_q ? (~hi_q + 1'b1) : hi_q);
        unique case (op_q)
            F3_MUL:                       result = prod_fix[W-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[2*W-1:W];
            F3_DIV, F3_DIVU:              result = quo_fix;
            default:                      result = rem_fix;
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d starts from its held value so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_lat_d  = rd_lat_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        a_d       = a_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        rd_d      = rd_q;
        rd_val_d  = rd_val_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && ready_q && !kill) begin
                    state_d   = ST_CALC;
                    cnt_d     = '0;
                    op_d      = op_in;
                    rd_lat_d  = rd_in;
                    hi_d      = '0;
                    lo_d      = a_mag;
                    b_d       = b_mag;
                    a_d       = rs1_val;
                    neg_d     = s1_neg ^ s2_neg;
                    neg_rem_d = s1_neg;
                    bzero_d   = (rs2_val == '0);
                end
            end

            ST_CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (is_div) begin
                    // Restoring step: keep the difference only if non-negative
                    if (!add_sum[W+1]) begin
                        hi_d = add_sum[W-1:0];
                        lo_d = {lo_q[W-2:0], 1'b1};
                    end else begin
                        hi_d = {hi_q[W-2:0], lo_q[W-1]};
                        lo_d = {lo_q[W-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add step: new partial sum shifts right into lo
                    hi_d = add_sum[W:1];
                    lo_d = {add_sum[0], lo_q[W-1:1]};
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                state_d  = ST_DONE;
                done_d   = 1'b1;
                wr_en_d  = (rd_lat_q != 5'd0);
                rd_d     = rd_lat_q;
                rd_val_d = result;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort: no completion, and the previous result stays visible
        if (kill && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            wr_en_d  = 1'b0;
            rd_d     = rd_q;
            rd_val_d = rd_val_q;
        end

        ready_d = (state_d == ST_IDLE);
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath is a handful of flops, not a memory array,
            // so everything is reset to give a clean, defined post-reset state.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= F3_MUL;
            rd_lat_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            a_q       <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_q      <= '0;
            rd_val_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together
            // from the values present before the edge.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_lat_q  <= rd_lat_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            a_q       <= a_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            rd_q      <= rd_d;
            rd_val_q  <= rd_val_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign wr_en  = wr_en_q;
    assign rd     = rd_q;
    assign rd_val = rd_val_q;

endmodule

// File: tb/tb_muldiv.sv
// -----------------------------------------------------------------------------
// tb_muldiv
// Directed testbench for muldiv: fixed-latency result checks for each RV32M
// op including divide-by-zero and signed overflow, busy-start/operand-change
// isolation, rd=0 suppression, kill, and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_muldiv;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   funct3;
    logic [W-1:0] rs1_val;
    logic [W-1:0] rs2_val;
    logic [4:0]   rd_in;
    logic         kill;
    logic         ready;
    logic         done;
    logic         wr_en;
    logic [4:0]   rd;
    logic [W-1:0] rd_val;

    int total = 0;
    int bad   = 0;

    muldiv #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .kill    (kill),
        .ready   (ready),
        .done    (done),
        .wr_en   (wr_en),
        .rd      (rd),
        .rd_val  (rd_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Run one op from acceptance (edge N) through the cycle after DONE.
    // With noisy=1, start stays high and the inputs change while busy.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] exp,
                          input bit noisy);
        int early;
        @(negedge clk);
        check({tag, " ready_before"}, 32'(ready), 32'd1);
        start   = 1'b1;
        funct3  = op;
        rs1_val = a;
        rs2_val = b;
        rd_in   = r;
        @(posedge clk);                  // edge N: accept
        #1;
        if (noisy) begin
            funct3  = ~op;
            rs1_val = ~a;
            rs2_val = b + 32'd3;
            rd_in   = r + 5'd1;
        end else begin
            start = 1'b0;
        end
        early = 0;
        for (int c = 1; c <= 33; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) check({tag, " busy"}, 32'(ready), 32'd0);
            if (c < 33 && (done || wr_en)) early++;
        end
        // now between edges N+33 and N+34
        check({tag, " done"},   32'(done),  32'd1);
        check({tag, " wr_en"},  32'(wr_en), 32'(r != 5'd0));
        check({tag, " rd"},     32'(rd),    32'(r));
        check({tag, " rd_val"}, rd_val,     exp);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " early_pulse"}, 32'(early), 32'd0);
        check({tag, " done_clr"},    32'({done, wr_en}), 32'd0);
        check({tag, " ready_after"}, 32'(ready), 32'd1);
        check({tag, " rd_val_hold"}, rd_val, exp);
    endtask

    // Expect no done/wr_en activity for n cycles
    task automatic watch_quiet(input string tag, input int n);
        int pulses;
        pulses = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done || wr_en) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        funct3  = 3'd0;
        rs1_val = '0;
        rs2_val = '0;
        rd_in   = '0;
        kill    = 1'b0;

        #12;
        check("rst ready",  32'(ready),  32'd1);
        check("rst done",   32'(done),   32'd0);
        check("rst wr_en",  32'(wr_en),  32'd0);
        check("rst rd",     32'(rd),     32'd0);
        check("rst rd_val", rd_val,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mulh_m1_m1",   F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 1'b0);
        run_op("mulhu_max",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 1'b0);
        run_op("mul_7_m3",     F3_MUL,    32'd7,         32'hFFFF_FFFD, 5'd7,  32'hFFFF_FFEB, 1'b0);
        run_op("mulhsu_m1",    F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0);
        run_op("div_m7_2",     F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_m7_2",     F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_100_0",   F3_DIVU,   32'd100,       32'd0,         5'd12, 32'hFFFF_FFFF, 1'b0);
        run_op("remu_100_0",   F3_REMU,   32'd100,       32'd0,         5'd13, 32'd100,       1'b0);
        run_op("div_m5_0",     F3_DIV,    32'hFFFF_FFFB, 32'd0,         5'd14, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_m5_0",     F3_REM,    32'hFFFF_FFFB, 32'd0,         5'd15, 32'hFFFF_FFFB, 1'b0);
        run_op("div_ovf",      F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1'b0);
        run_op("rem_ovf",      F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1'b0);
        run_op("divu_max_3",   F3_DIVU,   32'hFFFF_FFFF, 32'd3,         5'd18, 32'h5555_5555, 1'b0);
        run_op("busy_mul_6_7", F3_MUL,    32'd6,         32'd7,         5'd9,  32'd42,        1'b1);
        run_op("rd0_mulhu",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFE, 1'b0);

        // kill in IDLE blocks a simultaneous start
        @(negedge clk);
        start   = 1'b1;
        kill    = 1'b1;
        funct3  = F3_DIVU;
        rs1_val = 32'd50;
        rs2_val = 32'd5;
        rd_in   = 5'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        check("idle_kill ready", 32'(ready), 32'd1);
        watch_quiet("idle_kill quiet", 40);

        // kill at CALC cycle 10
        @(negedge clk);
        start   = 1'b1;
        funct3  = F3_DIV;
        rs1_val = 32'd100;
        rs2_val = 32'd7;
        rd_in   = 5'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill ready", 32'(ready), 32'd1);
        check("kill done",  32'({done, wr_en}), 32'd0);
        watch_quiet("kill quiet", 40);
        run_op("post_kill_div", F3_DIV, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0);

        // reset at CALC cycle 20
        @(negedge clk);
        start   = 1'b1;
        funct3  = F3_REMU;
        rs1_val = 32'd100;
        rs2_val = 32'd7;
        rd_in   = 5'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst ready",  32'(ready), 32'd1);
        check("midrst done",   32'({done, wr_en}), 32'd0);
        check("midrst rd",     32'(rd), 32'd0);
        check("midrst rd_val", rd_val,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("midrst quiet", 40);
        run_op("post_rst_remu", F3_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
